// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, FSM state type and prefetch slot type
package fetch_pkg;

  localparam int ILEN     = 32;
  localparam int PC_INCR  = 4;
  // Slot PC storage is sized for the widest supported XLEN; narrower
  // configurations zero-extend on write and truncate on read.
  localparam int PC_W_MAX = 64;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W_MAX-1:0] pc;
    logic [ILEN-1:0]     instr;
    logic                filled;
  } slot_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - in-order slot FIFO: reserve at tail, fill oldest unfilled, pop head
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     reserve_i,
  input  logic [XLEN-1:0]          reserve_pc_i,
  input  logic                     fill_i,
  input  logic [ILEN-1:0]          fill_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   unfilled_o,
  output logic                     head_filled_o,
  output logic [ILEN-1:0]          head_instr_o,
  output logic [XLEN-1:0]          head_pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  slot_t         slots_q [DEPTH];
  slot_t         slots_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fill_ptr_q, fill_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] unfilled_q, unfilled_d;
  logic          do_fill;
  logic          do_pop;
  logic          do_reserve;

  // Next-state for slot contents, pointers and occupancy; flush clears everything.
  always_comb begin
    slots_d    = slots_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    // A fill with no reserved-unfilled slot is a stray response and is ignored.
    do_fill    = fill_i && (unfilled_q != '0);
    do_pop     = pop_i && (count_q != '0);
    do_reserve = reserve_i && (count_q != CW'(DEPTH));
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_d[i] = '0;
      end
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      count_d    = '0;
      unfilled_d = '0;
    end else begin
      if (do_fill) begin
        slots_d[fill_ptr_q].instr  = fill_data_i;
        slots_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d                 = fill_ptr_q + 1'b1;
      end
      // The tail slot is never the fill target: it is free until this cycle.
      if (do_reserve) begin
        slots_d[wr_ptr_q].pc     = PC_W_MAX'(reserve_pc_i);
        slots_d[wr_ptr_q].instr  = '0;
        slots_d[wr_ptr_q].filled = 1'b0;
        wr_ptr_d                 = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d    = count_q + CW'(do_reserve) - CW'(do_pop);
      unfilled_d = unfilled_q + CW'(do_reserve) - CW'(do_fill);
    end
  end

  // Slot storage and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
    end else begin
      slots_q    <= slots_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
    end
  end

  assign count_o       = count_q;
  assign unfilled_o    = unfilled_q;
  assign head_filled_o = (count_q != '0) && slots_q[rd_ptr_q].filled;
  assign head_instr_o  = slots_q[rd_ptr_q].instr;
  assign head_pc_o     = XLEN'(slots_q[rd_ptr_q].pc);

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetch: BOOT/RUN FSM, fetch PC, redirect discard; PREFETCH_BYPASS_EN adds same-cycle response bypass
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   fifo_unfilled;
  logic            head_filled;
  logic [ILEN-1:0] head_instr;
  logic [XLEN-1:0] head_pc;

  logic            grant;
  logic            any_outstanding;
  logic            resp_drop;
  logic            resp_fill;
  logic            bypass;
  logic            transfer;

  // FSM, request generation, fetch PC and discard counter next-state.
  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    discard_d       = discard_q;
    imem_req_o      = (state_q == ST_RUN) && (fifo_count != CW'(DEPTH));
    grant           = imem_req_o && imem_gnt_i;
    any_outstanding = (discard_q != '0) || (fifo_unfilled != '0);
    // Responses belonging to pre-redirect requests come first (in order),
    // so they are dropped until the discard counter runs out.
    resp_drop       = imem_rvalid_i && (discard_q != '0);
    resp_fill       = imem_rvalid_i && (discard_q == '0) && (fifo_unfilled != '0);

    if (state_q == ST_BOOT) begin
      state_d = ST_RUN;
    end

    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
      // Everything still owed by memory becomes garbage: already-discarding
      // requests, live unfilled slots and a same-cycle grant, less a
      // same-cycle response that retires one of them.
      discard_d  = discard_q + fifo_unfilled + CW'(grant)
                 - CW'(imem_rvalid_i && any_outstanding);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_INCR);
      end
      if (resp_drop) begin
        discard_d = discard_q - 1'b1;
      end
    end
  end

  // Decode-side presentation of the head slot, optionally bypassing the response.
  always_comb begin
    bypass     = 1'b0;
    instr_o    = head_instr;
    instr_pc_o = head_pc;
`ifdef PREFETCH_BYPASS_EN
    // resp_fill with an unfilled head means the response is for the head.
    bypass     = resp_fill && !head_filled;
    if (bypass) begin
      instr_o = imem_rdata_i;
    end
`endif
    instr_valid_o = (head_filled || bypass) && !redirect_i;
    transfer      = instr_valid_o && instr_ready_i;
  end

  // State, fetch PC and discard counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign imem_addr_o = fetch_pc_q;

  prefetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (redirect_i),
    .reserve_i     (grant && !redirect_i),
    .reserve_pc_i  (fetch_pc_q),
    .fill_i        (resp_fill && !redirect_i),
    .fill_data_i   (imem_rdata_i),
    .pop_i         (transfer),
    .count_o       (fifo_count),
    .unfilled_o    (fifo_unfilled),
    .head_filled_o (head_filled),
    .head_instr_o  (head_instr),
    .head_pc_o     (head_pc)
  );

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - scoreboard bench for prefetch_unit with a modelled instruction memory
module tb_prefetch_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef PREFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  prefetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          lat    = 1;
  int          gcount = 0;
  bit          gnt_en = 1'b0;
  bit          rdy    = 1'b1;
  bit          redir  = 1'b0;
  logic [31:0] redir_pc = '0;
  logic [31:0] next_addr = '0;
  logic [31:0] mem_addr_q [$];
  int          mem_due_q  [$];
  logic [31:0] exp_pc_q   [$];
  logic [31:0] xfer_log   [$];
  logic        o_req, o_valid;
  logic [31:0] o_addr, o_instr, o_pc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // One clock: drive memory response and controls, sample mid-cycle, update models.
  task automatic cycle();
    logic [31:0] exp_pc;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = data_of(mem_addr_q[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
    imem_gnt_i    = gnt_en;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = redir_pc;
    #1;
    o_req   = imem_req_o;
    o_addr  = imem_addr_o;
    o_valid = instr_valid_o;
    o_instr = instr_o;
    o_pc    = instr_pc_o;
    if (!reset) begin
      if (o_req) begin
        checks++;
        if (o_addr !== next_addr) begin
          errors++;
          $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, o_addr, next_addr);
        end
      end
      if (o_valid && rdy) begin
        checks++;
        if (exp_pc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_instr cyc=%0d: got pc %h expected no transfer", cyc, o_pc);
        end else begin
          exp_pc = exp_pc_q.pop_front();
          if (o_pc !== exp_pc || o_instr !== data_of(exp_pc)) begin
            errors++;
            $display("FAIL instr cyc=%0d: got pc %h instr %h expected pc %h instr %h",
                     cyc, o_pc, o_instr, exp_pc, data_of(exp_pc));
          end
          xfer_log.push_back(o_pc);
        end
      end
      if (o_req && gnt_en) begin
        mem_addr_q.push_back(next_addr);
        mem_due_q.push_back(cyc + lat);
        exp_pc_q.push_back(next_addr);
        next_addr = next_addr + 32'd4;
        gcount++;
      end
      if (redir) begin
        exp_pc_q.delete();
        next_addr = {redir_pc[31:2], 2'b00};
      end
    end
    if (imem_rvalid_i) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    redir = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    gnt_en = 1'b0;
    reset  = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    exp_pc_q.delete();
    xfer_log.delete();
    next_addr = 32'h0;
    gcount    = 0;
  endtask

  task automatic drain();
    gnt_en = 1'b0;
    rdy    = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (mem_addr_q.size() == 0 && exp_pc_q.size() == 0) break;
      cycle();
    end
    checks++;
    if (exp_pc_q.size() != 0 || mem_addr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d instrs %0d responses pending expected 0 and 0",
               exp_pc_q.size(), mem_addr_q.size());
    end
  endtask

  task automatic test_reset();
    rdy    = 1'b1;
    lat    = 1;
    gnt_en = 1'b0;
    reset  = 1'b1;
    cycle();
    #1;
    checks++;
    if (imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_req: got %b expected 0", imem_req_o);
    end
    checks++;
    if (instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", instr_valid_o);
    end
    checks++;
    if (instr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_instr: got %h expected 0", instr_o);
    end
    checks++;
    if (instr_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: got %h expected 0", instr_pc_o);
    end
    cycle();
    reset     = 1'b0;
    next_addr = 32'h0;
    gcount    = 0;
    xfer_log.delete();
    gnt_en = 1'b1;
    cycle();
    checks++;
    if (o_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_req: got %b expected 0", o_req);
    end
  endtask

  task automatic test_stream();
    gnt_en = 1'b1;
    rdy    = 1'b1;
    lat    = 1;
    cycle();
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      errors++;
      $display("FAIL stream_first_req: got req %b addr %h expected 1 00000000", o_req, o_addr);
    end
    repeat (11) cycle();
    checks++;
    if (xfer_log.size() < 8) begin
      errors++;
      $display("FAIL stream_count: got %0d expected >= 8", xfer_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xfer_log[i] !== 32'(i * 4)) begin
          errors++;
          $display("FAIL stream_pc%0d: got %h expected %h", i, xfer_log[i], 32'(i * 4));
        end
      end
    end
    drain();
  endtask

  task automatic test_full();
    do_reset();
    rdy    = 1'b0;
    gnt_en = 1'b1;
    lat    = 1;
    repeat (10) cycle();
    checks++;
    if (gcount !== 4 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL full_grants: got %0d grants req %b expected 4 grants req 0", gcount, o_req);
    end
    rdy = 1'b1;
    cycle();
    checks++;
    if (xfer_log.size() !== 1 || o_req !== 1'b0) begin
      errors++;
      $display("FAIL full_pop: got %0d transfers req %b expected 1 transfer req 0",
               xfer_log.size(), o_req);
    end
    rdy = 1'b0;
    cycle();
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h10) begin
      errors++;
      $display("FAIL full_next_req: got req %b addr %h expected 1 00000010", o_req, o_addr);
    end
    drain();
  endtask

  task automatic test_redirect();
    do_reset();
    rdy    = 1'b1;
    lat    = 4;
    gnt_en = 1'b1;
    cycle();
    cycle();
    cycle();
    gnt_en   = 1'b0;
    redir    = 1'b1;
    redir_pc = 32'h103;
    cycle();
    gnt_en = 1'b1;
    cycle();
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h100) begin
      errors++;
      $display("FAIL redirect_addr: got req %b addr %h expected 1 00000100", o_req, o_addr);
    end
    repeat (10) cycle();
    checks++;
    if (xfer_log.size() == 0 || xfer_log[0] !== 32'h100) begin
      errors++;
      $display("FAIL redirect_first_pc: got %0d transfers first %h expected first 00000100",
               xfer_log.size(), (xfer_log.size() > 0) ? xfer_log[0] : 32'hx);
    end
    drain();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    rdy    = 1'b1;
    lat    = 1;
    gnt_en = 1'b1;
    cycle();
    cycle();
    redir    = 1'b1;
    redir_pc = 32'h200;
    cycle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL redirect_masks_valid: got %b expected 0", o_valid);
    end
    cycle();
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h200) begin
      errors++;
      $display("FAIL redirect_same_addr: got req %b addr %h expected 1 00000200", o_req, o_addr);
    end
    repeat (6) cycle();
    checks++;
    if (xfer_log.size() == 0 || xfer_log[0] !== 32'h200) begin
      errors++;
      $display("FAIL redirect_same_first_pc: got %0d transfers expected first 00000200",
               xfer_log.size());
    end
    drain();
  endtask

  task automatic test_stall_wrap();
    do_reset();
    rdy      = 1'b1;
    lat      = 1;
    gnt_en   = 1'b0;
    redir    = 1'b1;
    redir_pc = 32'hFFFF_FFFC;
    cycle();
    checks++;
    if (o_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_redirect_req: got %b expected 0", o_req);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
        errors++;
        $display("FAIL stall_hold%0d: got req %b addr %h expected 1 fffffffc", i, o_req, o_addr);
      end
    end
    gnt_en = 1'b1;
    cycle();
    cycle();
    checks++;
    if (o_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h expected 00000000", o_addr);
    end
    drain();
    checks++;
    if (xfer_log.size() < 2 || xfer_log[0] !== 32'hFFFF_FFFC || xfer_log[1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pcs: got %0d transfers expected fffffffc then 00000000", xfer_log.size());
    end
  endtask

  task automatic test_bypass_latency();
    do_reset();
    rdy    = 1'b1;
    lat    = 1;
    gnt_en = 1'b1;
    cycle();
    cycle();
    gnt_en = 1'b0;
    cycle();
    checks++;
    if (o_valid !== BYP) begin
      errors++;
      $display("FAIL resp_cycle_valid: got %b expected %b", o_valid, BYP);
    end
    cycle();
    checks++;
    if (o_valid !== !BYP) begin
      errors++;
      $display("FAIL after_resp_valid: got %b expected %b", o_valid, !BYP);
    end
    checks++;
    if (xfer_log.size() !== 1 || xfer_log[0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_xfer: got %0d transfers expected 1 at pc 0", xfer_log.size());
    end
    drain();
  endtask

  task automatic test_stray_and_reset_mid();
    do_reset();
    rdy    = 1'b1;
    lat    = 1;
    gnt_en = 1'b0;
    cycle();
    mem_addr_q.push_back(32'hDEAD_BEE0);
    mem_due_q.push_back(cyc);
    cycle();
    cycle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ignored: got valid %b expected 0", o_valid);
    end
    gnt_en = 1'b1;
    cycle();
    cycle();
    drain();
    gnt_en = 1'b1;
    rdy    = 1'b0;
    lat    = 3;
    repeat (4) cycle();
    do_reset();
    rdy = 1'b1;
    cycle();
    cycle();
    cycle();
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_after_reset: got valid %b expected 0", o_valid);
    end
    gnt_en = 1'b1;
    lat    = 1;
    repeat (3) cycle();
    drain();
    checks++;
    if (xfer_log.size() == 0 || xfer_log[0] !== 32'h0) begin
      errors++;
      $display("FAIL restart_pc: got %0d transfers expected first at 00000000", xfer_log.size());
    end
  endtask

  initial begin
    reset         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b1;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_same_cycle();
    test_stall_wrap();
    test_bypass_latency();
    test_stray_and_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
